// File: rtl/fix_query_arbiter_pkg.sv
// Shared types for the query arbiter: FSM state encoding and statistics counter width.
package fix_qarb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} qarb_state_t;

  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/fix_query_arbiter_if.sv
// Host query ports plus the parser lookup path, bundled for the arbiter.
interface fix_query_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int MSG_W   = 10,
  parameter int TAG_W   = 32,
  parameter int VAL_W   = 256
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ*TAG_W-1:0] req_tag_i;
  logic [NUM_REQ*MSG_W-1:0] req_msg_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic                     resp_valid_o;
  logic [ID_W-1:0]          resp_id_o;
  logic                     resp_hit_o;
  logic [VAL_W-1:0]         resp_value_o;
  logic                     read_message_o;
  logic [TAG_W-1:0]         find_tag_o;
  logic [MSG_W-1:0]         message_num_o;
  logic [VAL_W-1:0]         value_i;
  logic                     value_valid_i;
  logic                     busy_o;

  modport slave (
    input  req_i, req_tag_i, req_msg_i, value_i, value_valid_i,
    output gnt_o, resp_valid_o, resp_id_o, resp_hit_o, resp_value_o,
           read_message_o, find_tag_o, message_num_o, busy_o
  );

  modport master (
    output req_i, req_tag_i, req_msg_i, value_i, value_valid_i,
    input  gnt_o, resp_valid_o, resp_id_o, resp_hit_o, resp_value_o,
           read_message_o, find_tag_o, message_num_o, busy_o
  );

endinterface

// File: rtl/fix_query_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module fix_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    id_o,
  output logic               any_o
);

  logic [ID_W-1:0] idx;

  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    any_o = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ID_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!any_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        id_o       = idx;
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fix_query_arbiter.sv
// Round-robin sharing of the parser's single lookup path between NUM_REQ host requesters.
// Optional FIX_QARB_STATS_EN adds saturating grant/miss/spurious-valid counters.
module fix_query_arbiter
  import fix_qarb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MSG_W   = 10,
  parameter int TAG_W   = 32,
  parameter int VAL_W   = 256,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  fix_query_arbiter_if.slave bus
`ifdef FIX_QARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] grant_cnt_o,
  output logic [STAT_W-1:0]         miss_cnt_o,
  output logic [STAT_W-1:0]         spur_cnt_o
`endif
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  qarb_state_t        state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [NUM_REQ-1:0] oh_q, oh_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [MSG_W-1:0]   msg_q, msg_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VAL_W-1:0]   val_q, val_d;
  logic               hit_q, hit_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [ID_W-1:0]    pick_id;
  logic               pick_any;

  fix_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i (bus.req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_oh),
    .id_o  (pick_id),
    .any_o (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      oh_q    <= '0;
      tag_q   <= '0;
      msg_q   <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      oh_q    <= oh_d;
      tag_q   <= tag_d;
      msg_q   <= msg_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      hit_q   <= hit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    oh_d    = oh_q;
    tag_d   = tag_q;
    msg_d   = msg_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    hit_d   = hit_q;
    case (state_q)
      IDLE: begin
        // Requests are only sampled here, so a requester that drops early simply is not picked.
        if (pick_any) begin
          id_d    = pick_id;
          oh_d    = pick_oh;
          tag_d   = bus.req_tag_i[pick_id*TAG_W +: TAG_W];
          msg_d   = bus.req_msg_i[pick_id*MSG_W +: MSG_W];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        ptr_d   = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.value_valid_i) begin
          val_d   = bus.value_i;
          hit_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          val_d   = '0;
          hit_d   = 1'b0;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt_o          = (state_q == ISSUE) ? oh_q : '0;
  assign bus.read_message_o = (state_q == ISSUE);
  assign bus.resp_valid_o   = (state_q == RESP);
  assign bus.resp_id_o      = id_q;
  assign bus.resp_hit_o     = hit_q;
  assign bus.resp_value_o   = val_q;
  assign bus.find_tag_o     = tag_q;
  assign bus.message_num_o  = msg_q;
  assign bus.busy_o         = (state_q != IDLE);

`ifdef FIX_QARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] gcnt_q;
  logic [STAT_W-1:0]              miss_q, spur_q;

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_gcnt
    always_ff @(posedge clk) begin
      if (rst)                                            gcnt_q[r] <= '0;
      else if (state_q == ISSUE && id_q == ID_W'(r))      gcnt_q[r] <= sat_inc(gcnt_q[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_q <= '0;
      spur_q <= '0;
    end else begin
      if (state_q == RESP && !hit_q)             miss_q <= sat_inc(miss_q);
      if (bus.value_valid_i && state_q != WAIT)  spur_q <= sat_inc(spur_q);
    end
  end

  assign grant_cnt_o = gcnt_q;
  assign miss_cnt_o  = miss_q;
  assign spur_cnt_o  = spur_q;
`endif

endmodule

// File: tb/tb_fix_query_arbiter.sv
// Bench for fix_query_arbiter: directed table, multi-cycle corner sequences and randomized traffic.
module tb_fix_query_arbiter;

  localparam int NUM_REQ = 4;
  localparam int MSG_W   = 10;
  localparam int TAG_W   = 32;
  localparam int VAL_W   = 256;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fix_query_arbiter_if #(.NUM_REQ(NUM_REQ), .MSG_W(MSG_W), .TAG_W(TAG_W), .VAL_W(VAL_W)) bus ();

`ifdef FIX_QARB_STATS_EN
  logic [NUM_REQ*16-1:0] grant_cnt;
  logic [15:0]           miss_cnt, spur_cnt;
`endif

  fix_query_arbiter #(
    .NUM_REQ(NUM_REQ), .MSG_W(MSG_W), .TAG_W(TAG_W), .VAL_W(VAL_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FIX_QARB_STATS_EN
    ,
    .grant_cnt_o (grant_cnt),
    .miss_cnt_o  (miss_cnt),
    .spur_cnt_o  (spur_cnt)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  int ptr_m  = 0;
  logic [TAG_W-1:0] tag_of [NUM_REQ];
  logic [MSG_W-1:0] msg_of [NUM_REQ];

  typedef struct {
    logic [NUM_REQ-1:0] add;
    logic [TAG_W-1:0]   tag;
    logic [MSG_W-1:0]   msg;
    int                 dly;
    int                 exp_id;
  } vec_t;

  task automatic chk(input string nm, input logic [VAL_W-1:0] act, input logic [VAL_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [TAG_W-1:0] t, input logic [MSG_W-1:0] m);
    bus.req_i[r] = 1'b1;
    tag_of[r] = t;
    msg_of[r] = m;
    bus.req_tag_i[r*TAG_W +: TAG_W] = t;
    bus.req_msg_i[r*MSG_W +: MSG_W] = m;
  endtask

  // Spec rule: first requesting index scanning upward from p, wrapping.
  function automatic int rr_pick(input logic [NUM_REQ-1:0] req, input int p);
    for (int k = 0; k < NUM_REQ; k++)
      if (req[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus.req_i = '0;
    bus.value_valid_i = 1'b0;
    bus.value_i = '0;
    tick();
    tick();
    rst = 1'b0;
    ptr_m = 0;
  endtask

  // Called in an IDLE cycle with requests set. dly = cycles after the strobe at which
  // value_valid_i is driven (0 = never). Ends in the response cycle.
  task automatic do_txn(input int exp_id, input int dly, input bit jitter, input string nm);
    int lat, got, exp_j;
    bit exp_hit, hold_ok;
    logic [VAL_W-1:0] v, exp_v;
    logic [TAG_W-1:0] t0;
    logic [MSG_W-1:0] m0;
    lat = 0;
    while (bus.gnt_o == '0 && lat < 4) begin
      tick();
      lat++;
    end
    chk({nm, "_gnt_lat"}, lat, 1);
    if (bus.gnt_o == '0) return;
    chk({nm, "_gnt"}, bus.gnt_o, VAL_W'(1) << exp_id);
    chk({nm, "_strobe"}, bus.read_message_o, 1);
    chk({nm, "_tag"}, bus.find_tag_o, tag_of[exp_id]);
    chk({nm, "_msg"}, bus.message_num_o, msg_of[exp_id]);
    for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
    exp_hit = (dly >= 1 && dly <= TIMEOUT);
    exp_j   = exp_hit ? dly + 1 : TIMEOUT + 1;
    exp_v   = exp_hit ? v : '0;
    t0 = bus.find_tag_o;
    m0 = bus.message_num_o;
    hold_ok = 1'b1;
    got = -1;
    for (int j = 1; j <= TIMEOUT + 4; j++) begin
      tick();
      if (bus.resp_valid_o) begin
        got = j;
        break;
      end
      if (bus.find_tag_o !== t0 || bus.message_num_o !== m0 || bus.busy_o !== 1'b1 ||
          bus.gnt_o !== '0 || bus.read_message_o !== 1'b0) hold_ok = 1'b0;
      bus.value_valid_i = (j == dly);
      bus.value_i = (j == dly) ? v : {8{$urandom}};
      if (jitter)
        for (int r = 0; r < NUM_REQ; r++)
          if (r != exp_id && $urandom_range(0, 7) == 0) begin
            if (bus.req_i[r]) bus.req_i[r] = 1'b0;
            else set_req(r, $urandom, MSG_W'($urandom));
          end
    end
    bus.value_valid_i = 1'b0;
    chk({nm, "_resp_cycle"}, got, exp_j);
    chk({nm, "_hold"}, hold_ok, 1);
    if (got > 0) begin
      chk({nm, "_resp_id"}, bus.resp_id_o, exp_id);
      chk({nm, "_resp_hit"}, bus.resp_hit_o, exp_hit);
      chk({nm, "_resp_value"}, bus.resp_value_o, exp_v);
    end
  endtask

  vec_t vecs [10];
  bit quiet;

  initial begin
    bus.req_i = '0;
    bus.req_tag_i = '0;
    bus.req_msg_i = '0;
    bus.value_i = '0;
    bus.value_valid_i = 1'b0;
    rst = 1'b1;

    // Arbitration table from reset; pending bits carry over between entries.
    vecs[0] = '{4'b0010, 32'd35,        10'd2,   2, 1};
    vecs[1] = '{4'b0001, 32'h0000_1111, 10'd7,   1, 0};
    vecs[2] = '{4'b1001, 32'h0000_2222, 10'd9,  16, 3};
    vecs[3] = '{4'b0000, 32'h0,         10'd0,   0, 0};
    vecs[4] = '{4'b1111, 32'hDEAD_BEEF, 10'd513, 3, 1};
    vecs[5] = '{4'b0000, 32'h0,         10'd0,  17, 2};
    vecs[6] = '{4'b0010, 32'hCAFE_0006, 10'd6,   5, 3};
    vecs[7] = '{4'b0000, 32'h0,         10'd0,   1, 0};
    vecs[8] = '{4'b0100, 32'h0BAD_F00D, 10'd1023, 9, 1};
    vecs[9] = '{4'b0000, 32'h0,         10'd0,  12, 2};

    do_reset();
    chk("reset_busy", bus.busy_o, 0);
    chk("reset_gnt", bus.gnt_o, 0);
    chk("reset_resp_valid", bus.resp_valid_o, 0);
    chk("reset_strobe", bus.read_message_o, 0);
    chk("reset_outs", {bus.find_tag_o, bus.message_num_o, bus.resp_id_o, bus.resp_hit_o}, 0);
    chk("reset_value", bus.resp_value_o, 0);

    for (int i = 0; i < 10; i++) begin
      for (int r = 0; r < NUM_REQ; r++)
        if (vecs[i].add[r] && !bus.req_i[r]) set_req(r, vecs[i].tag + r, vecs[i].msg);
      do_txn(vecs[i].exp_id, vecs[i].dly, 1'b0, $sformatf("vec%0d", i));
      bus.req_i[vecs[i].exp_id] = 1'b0;
      tick();
    end

    // All requesters held continuously: strict rotation 0,1,2,3,0.
    do_reset();
    for (int r = 0; r < NUM_REQ; r++) set_req(r, 32'h5000 + r, MSG_W'(r));
    for (int k = 0; k < 5; k++) begin
      do_txn(k % NUM_REQ, 1, 1'b0, $sformatf("hold%0d", k));
      tick();
    end

    // Reset while waiting on the parser aborts silently and resets the pointer.
    do_reset();
    bus.req_i = '0;
    set_req(2, 32'h7777, 10'd77);
    tick();
    chk("abort_gnt", bus.gnt_o, 4'b0100);
    tick();
    tick();
    bus.req_i = '0;
    rst = 1'b1;
    tick();
    chk("abort_busy", bus.busy_o, 0);
    chk("abort_outs", {bus.gnt_o, bus.read_message_o, bus.resp_valid_o, bus.resp_hit_o,
                       bus.resp_id_o, bus.find_tag_o, bus.message_num_o}, 0);
    rst = 1'b0;
    ptr_m = 0;
    quiet = 1'b1;
    for (int j = 0; j < TIMEOUT + 4; j++) begin
      tick();
      if (bus.resp_valid_o || bus.busy_o) quiet = 1'b0;
    end
    chk("abort_no_resp", quiet, 1);
    set_req(0, 32'hA0, 10'd10);
    set_req(3, 32'hA3, 10'd13);
    do_txn(0, 2, 1'b0, "post_abort");
    bus.req_i = '0;
    tick();

    // Randomized traffic with requesters joining and forfeiting while a lookup is in flight.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      int exp_id, dly;
      for (int r = 0; r < NUM_REQ; r++)
        if (!bus.req_i[r] && $urandom_range(0, 2) == 0) set_req(r, $urandom, MSG_W'($urandom));
      if (bus.req_i == '0) set_req($urandom_range(0, NUM_REQ - 1), $urandom, MSG_W'($urandom));
      exp_id = rr_pick(bus.req_i, ptr_m);
      dly = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, TIMEOUT + 2);
      do_txn(exp_id, dly, 1'b1, $sformatf("rnd%0d", n));
      ptr_m = (exp_id + 1) % NUM_REQ;
      bus.req_i[exp_id] = 1'b0;
      tick();
    end

`ifdef FIX_QARB_STATS_EN
    do_reset();
    bus.req_i = '0;
    chk("stats_reset", {grant_cnt, miss_cnt, spur_cnt}, 0);
    bus.value_valid_i = 1'b1;
    bus.value_i = '1;
    tick();
    bus.value_valid_i = 1'b0;
    chk("stats_spur", spur_cnt, 1);
    set_req(1, 32'h51, 10'd5);
    do_txn(1, 0, 1'b0, "stats_miss_txn");
    bus.req_i = '0;
    tick();
    chk("stats_miss", miss_cnt, 1);
    chk("stats_grant", grant_cnt, 64'h0000_0000_0001_0000);
    chk("stats_spur_hold", spur_cnt, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
